// File: rtl/vt52_command_handler_pkg.sv
// Shared constants, state encoding and small helpers for the VT52 command handler.
package vt52_command_handler_pkg;

  localparam int SCREEN_COLS = 64;
  localparam int SCREEN_ROWS = 16;
  localparam logic [5:0] MAX_COL = 6'(SCREEN_COLS - 1);
  localparam logic [3:0] MAX_ROW = 4'(SCREEN_ROWS - 1);

  localparam logic [7:0] CLEAR_CHAR_DEF = 8'h20;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_TAB = 8'h09;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_ESC = 8'h1B;

  localparam logic [7:0] ESC_UP      = 8'h41;  // 'A'
  localparam logic [7:0] ESC_DOWN    = 8'h42;  // 'B'
  localparam logic [7:0] ESC_RIGHT   = 8'h43;  // 'C'
  localparam logic [7:0] ESC_LEFT    = 8'h44;  // 'D'
  localparam logic [7:0] ESC_HOME    = 8'h48;  // 'H'
  localparam logic [7:0] ESC_CLR_EOS = 8'h4A;  // 'J'
  localparam logic [7:0] ESC_CLR_EOL = 8'h4B;  // 'K'
  localparam logic [7:0] ESC_ADDR    = 8'h59;  // 'Y'

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ESC   = 3'd1,
    ST_Y_ROW = 3'd2,
    ST_Y_COL = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  function automatic logic [3:0] phys_row(input logic [3:0] top, input logic [3:0] lrow);
    return top + lrow;
  endfunction

  // ESC Y coordinates are offset by 0x20 and saturate at the screen edge.
  function automatic logic [3:0] ysat_row(input logic [7:0] b);
    logic [7:0] v;
    v = (b < 8'h20) ? 8'h00 : b - 8'h20;
    return (v > {4'h0, MAX_ROW}) ? MAX_ROW : v[3:0];
  endfunction

  function automatic logic [5:0] ysat_col(input logic [7:0] b);
    logic [7:0] v;
    v = (b < 8'h20) ? 8'h00 : b - 8'h20;
    return (v > {2'b00, MAX_COL}) ? MAX_COL : v[5:0];
  endfunction

endpackage

// File: rtl/vt52_clear_engine.sv
// Sequential position walker for clear/scroll fills: emits one logical (row, col)
// per cycle from the start position through (end_row, last column).
module vt52_clear_engine
  import vt52_command_handler_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [3:0] start_row,
  input  logic [5:0] start_col,
  input  logic [3:0] end_row,
  output logic       wr,
  output logic [3:0] row,
  output logic [5:0] col,
  output logic       done
);

  logic       busy_r;
  logic       done_r;
  logic [3:0] row_r;
  logic [5:0] col_r;
  logic [3:0] end_row_r;
  logic [3:0] lim_row_s;
  logic       last_s;

  // The start cycle writes the start position directly so no cycle is lost.
  assign wr        = start | busy_r;
  assign row       = start ? start_row : row_r;
  assign col       = start ? start_col : col_r;
  assign lim_row_s = start ? end_row : end_row_r;
  assign last_s    = (row == lim_row_s) && (col == MAX_COL);
  assign done      = done_r;

  // Position counter, column-first then row; done pulses the cycle after the last write.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      row_r     <= 4'd0;
      col_r     <= 6'd0;
      end_row_r <= 4'd0;
    end else begin
      done_r <= wr & last_s;
      if (wr) begin
        busy_r    <= ~last_s;
        end_row_r <= lim_row_s;
        if (col == MAX_COL) begin
          col_r <= 6'd0;
          row_r <= row + 4'd1;
        end else begin
          col_r <= col + 6'd1;
          row_r <= row;
        end
      end else begin
        busy_r    <= busy_r;
        end_row_r <= end_row_r;
        col_r     <= col_r;
        row_r     <= row_r;
      end
    end
  end

endmodule

// File: rtl/vt52_command_handler.sv
// VT52 byte-stream decoder: writes characters into the 64x16 buffer, tracks the
// cursor and scroll offset, and runs multi-cycle clears through vt52_clear_engine.
module vt52_command_handler
  import vt52_command_handler_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = CLEAR_CHAR_DEF,
  parameter int         COLS       = 64,
  parameter int         ROWS       = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic [9:0] buffer_waddr,
  output logic [7:0] buffer_din,
  output logic       buffer_wen,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic [3:0] top_row
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_e     state_r, state_nxt_s;
  logic       ready_r, wen_r;
  logic [9:0] waddr_r, waddr_nxt_s;
  logic [7:0] din_r, din_nxt_s;
  logic [3:0] row_r, row_nxt_s, top_r, top_nxt_s, yrow_r, yrow_nxt_s;
  logic [5:0] col_r, col_nxt_s;
  logic       accept_s, char_wen_s;
  logic [6:0] tab_s;
  logic       eng_start_s, eng_wr_s, eng_done_s;
  logic [3:0] eng_srow_s, eng_erow_s, eng_row_s;
  logic [5:0] eng_scol_s, eng_col_s;

  assign accept_s = data_valid & ready_r;
  assign tab_s    = {1'b0, col_r | 6'd7} + 7'd1;

  vt52_clear_engine u_clear (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (eng_start_s),
    .start_row (eng_srow_s),
    .start_col (eng_scol_s),
    .end_row   (eng_erow_s),
    .wr        (eng_wr_s),
    .row       (eng_row_s),
    .col       (eng_col_s),
    .done      (eng_done_s)
  );

  // Byte decode and cursor/escape state machine next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    top_nxt_s   = top_r;
    yrow_nxt_s  = yrow_r;
    char_wen_s  = 1'b0;
    eng_start_s = 1'b0;
    eng_srow_s  = row_r;
    eng_scol_s  = col_r;
    eng_erow_s  = LAST_ROW;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if ((data_in >= 8'h20) && (data_in <= 8'h7E)) begin
            char_wen_s = 1'b1;
            col_nxt_s  = (col_r == LAST_COL) ? LAST_COL : col_r + 6'd1;
          end else begin
            case (data_in)
              CHR_CR:  col_nxt_s = 6'd0;
              CHR_BS:  col_nxt_s = (col_r == 6'd0) ? 6'd0 : col_r - 6'd1;
              CHR_TAB: col_nxt_s = (tab_s > {1'b0, LAST_COL}) ? LAST_COL : tab_s[5:0];
              CHR_ESC: state_nxt_s = ST_ESC;
              CHR_LF: begin
                if (row_r == LAST_ROW) begin
                  // Scroll: the old top line becomes the new bottom line and is blanked.
                  top_nxt_s   = top_r + 4'd1;
                  eng_start_s = 1'b1;
                  eng_srow_s  = LAST_ROW;
                  eng_scol_s  = 6'd0;
                  eng_erow_s  = LAST_ROW;
                  state_nxt_s = ST_CLEAR;
                end else begin
                  row_nxt_s = row_r + 4'd1;
                end
              end
              default: state_nxt_s = ST_IDLE;
            endcase
          end
        end
        ST_ESC: begin
          state_nxt_s = ST_IDLE;
          case (data_in)
            ESC_UP:    row_nxt_s = (row_r == 4'd0) ? 4'd0 : row_r - 4'd1;
            ESC_DOWN:  row_nxt_s = (row_r == LAST_ROW) ? LAST_ROW : row_r + 4'd1;
            ESC_RIGHT: col_nxt_s = (col_r == LAST_COL) ? LAST_COL : col_r + 6'd1;
            ESC_LEFT:  col_nxt_s = (col_r == 6'd0) ? 6'd0 : col_r - 6'd1;
            ESC_HOME: begin
              row_nxt_s = 4'd0;
              col_nxt_s = 6'd0;
            end
            ESC_CLR_EOS: begin
              eng_start_s = 1'b1;
              eng_erow_s  = LAST_ROW;
              state_nxt_s = ST_CLEAR;
            end
            ESC_CLR_EOL: begin
              eng_start_s = 1'b1;
              eng_erow_s  = row_r;
              state_nxt_s = ST_CLEAR;
            end
            ESC_ADDR: state_nxt_s = ST_Y_ROW;
            default:  state_nxt_s = ST_IDLE;
          endcase
        end
        ST_Y_ROW: begin
          yrow_nxt_s  = ysat_row(data_in);
          state_nxt_s = ST_Y_COL;
        end
        ST_Y_COL: begin
          row_nxt_s   = yrow_r;
          col_nxt_s   = ysat_col(data_in);
          state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = ((state_r == ST_CLEAR) && eng_done_s) ? ST_IDLE : state_r;
    end
  end

  assign waddr_nxt_s = eng_wr_s   ? {phys_row(top_nxt_s, eng_row_s), eng_col_s} :
                       char_wen_s ? {phys_row(top_r, row_r), col_r} : waddr_r;
  assign din_nxt_s   = eng_wr_s   ? CLEAR_CHAR :
                       char_wen_s ? data_in : din_r;

  // Registered state and outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      wen_r   <= 1'b0;
      waddr_r <= 10'd0;
      din_r   <= 8'd0;
      row_r   <= 4'd0;
      col_r   <= 6'd0;
      top_r   <= 4'd0;
      yrow_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_CLEAR);
      wen_r   <= char_wen_s | eng_wr_s;
      waddr_r <= waddr_nxt_s;
      din_r   <= din_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      top_r   <= top_nxt_s;
      yrow_r  <= yrow_nxt_s;
    end
  end

  assign ready        = ready_r;
  assign buffer_wen   = wen_r;
  assign buffer_waddr = waddr_r;
  assign buffer_din   = din_r;
  assign cursor_row   = row_r;
  assign cursor_col   = col_r;
  assign top_row      = top_r;

endmodule

// File: tb/tb_vt52_command_handler.sv
// Randomized scoreboard bench for vt52_command_handler against a byte-level screen model.
module tb_vt52_command_handler;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic [9:0] buffer_waddr;
  logic [7:0] buffer_din;
  logic       buffer_wen;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic [3:0] top_row;

  vt52_command_handler dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .ready        (ready),
    .buffer_waddr (buffer_waddr),
    .buffer_din   (buffer_din),
    .buffer_wen   (buffer_wen),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .top_row      (top_row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];          // expected writes: addr*256 + data
  logic [7:0] esc_q[$];  // pending escape sequence bytes
  int m_row, m_col, m_top;
  int low_left;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int ysat(input logic [7:0] b, input int mx);
    int v;
    v = (b < 8'h20) ? 0 : int'(b) - 32;
    return (v > mx) ? mx : v;
  endfunction

  // Queue CLEAR_CHAR writes from logical (r,c) through (er,63); returns the count.
  function automatic int m_clear(input int r, input int c, input int er);
    int n = 0;
    for (int rr = r; rr <= er; rr++)
      for (int cc = ((rr == r) ? c : 0); cc < 64; cc++) begin
        exp_q.push_back(((((m_top + rr) % 16) * 64) + cc) * 256 + 32);
        n++;
      end
    return n;
  endfunction

  function automatic int m_byte(input logic [7:0] b);
    int n = 0;
    int letter;
    if (esc_q.size() == 0) begin
      if (b == 8'h1B) esc_q.push_back(b);
      else if (b >= 8'h20 && b <= 8'h7E) begin
        exp_q.push_back(((((m_top + m_row) % 16) * 64) + m_col) * 256 + int'(b));
        m_col = (m_col < 63) ? m_col + 1 : 63;
      end
      else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h08) m_col = (m_col > 0) ? m_col - 1 : 0;
      else if (b == 8'h09) m_col = (((m_col | 7) + 1) > 63) ? 63 : (m_col | 7) + 1;
      else if (b == 8'h0A) begin
        if (m_row < 15) m_row++;
        else begin
          m_top = (m_top + 1) % 16;
          n = m_clear(15, 0, 15);
        end
      end
    end else begin
      esc_q.push_back(b);
      letter = int'(esc_q[1]);
      if (letter == 8'h59) begin
        if (esc_q.size() == 4) begin
          m_row = ysat(esc_q[2], 15);
          m_col = ysat(esc_q[3], 63);
          esc_q.delete();
        end
      end else begin
        case (letter)
          8'h41: m_row = (m_row > 0) ? m_row - 1 : 0;
          8'h42: m_row = (m_row < 15) ? m_row + 1 : 15;
          8'h43: m_col = (m_col < 63) ? m_col + 1 : 63;
          8'h44: m_col = (m_col > 0) ? m_col - 1 : 0;
          8'h48: begin m_row = 0; m_col = 0; end
          8'h4A: n = m_clear(m_row, m_col, 15);
          8'h4B: n = m_clear(m_row, m_col, m_row);
          default: ;
        endcase
        esc_q.delete();
      end
    end
    return n;
  endfunction

  task automatic tick();
    chk("ready_idle", int'(ready), (low_left > 0) ? 0 : 1);
    @(negedge clk);
    if (low_left > 0) low_left--;
  endtask

  // Offer a byte and hold it until accepted; ready is checked every waiting cycle.
  task automatic send(input logic [7:0] b);
    int t = 0;
    int n;
    data_in    = b;
    data_valid = 1'b1;
    forever begin
      chk("ready_wait", int'(ready), (low_left > 0) ? 0 : 1);
      if (ready) break;
      if (t > 3000) begin
        chk("accept_timeout", 0, 1);
        data_valid = 1'b0;
        return;
      end
      t++;
      @(negedge clk);
      if (low_left > 0) low_left--;
    end
    @(posedge clk);
    n = m_byte(b);
    low_left = n;
    @(negedge clk);
    data_valid = 1'b0;
    chk("cursor_row", int'(cursor_row), m_row);
    chk("cursor_col", int'(cursor_col), m_col);
    chk("top_row", int'(top_row), m_top);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", int'(ready), 1);
    chk("rst_wen", int'(buffer_wen), 0);
    chk("rst_waddr", int'(buffer_waddr), 0);
    chk("rst_din", int'(buffer_din), 0);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_top", int'(top_row), 0);
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_top = 0; low_left = 0;
    esc_q.delete();
    exp_q.delete();
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && buffer_wen === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", int'(buffer_waddr), -1);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("waddr", int'(buffer_waddr), e / 256);
        chk("din", int'(buffer_din), e % 256);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    logic [7:0] ctl [4];
    logic [7:0] mv [5];
    ctl = '{8'h0D, 8'h0A, 8'h08, 8'h09};
    mv  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48};
    clr_n = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    clr_n = 1'b1;
    @(negedge clk);

    send(8'h41);
    send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
    send(8'h78);
    // ESC J from (14,60): 68 writes, next bytes offered while busy
    send(8'h1B); send(8'h59); send(8'h2E); send(8'h5C);
    send(8'h1B); send(8'h4A);
    send(8'h1B); send(8'h59); send(8'h2F); send(8'h23);
    send(8'h0A);
    repeat (70) tick();
    send(8'h1B); send(8'h59); send(8'h20); send(8'h7E);
    send(8'h61); send(8'h62);
    for (int i = 0; i < 70; i++) send(8'h08);
    send(8'h1B); send(8'h1B); send(8'h41);
    send(8'h09); send(8'h09);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: send(8'($urandom_range(32, 126)));
        4: send(ctl[$urandom_range(0, 3)]);
        5: send(8'($urandom_range(0, 255)));
        6: begin send(8'h1B); send(mv[$urandom_range(0, 4)]); end
        7: begin send(8'h1B); send(($urandom_range(0, 3) == 0) ? 8'h4A : 8'h4B); end
        8: begin
          send(8'h1B); send(8'h59);
          send(8'($urandom_range(0, 127))); send(8'($urandom_range(0, 127)));
        end
        default: repeat ($urandom_range(1, 4)) tick();
      endcase
    end
    while (esc_q.size() != 0) send(8'h48);
    repeat (1100) tick();

    // Reset in the middle of ESC K
    send(8'h1B); send(8'h59); send(8'h23); send(8'h2A);
    send(8'h1B); send(8'h4B);
    repeat (5) tick();
    clr_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) tick();
    send(8'h51);
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
